// File: rtl/clk_div_pkg.sv
// Shared defaults for the clock divider bank and the channel-select width helper.
package clk_div_pkg;

  localparam int C_NCH     = 4;
  localparam int C_WIDTH   = 20;
  localparam int C_DEF_DIV = 65000;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: count 0..div, tick and toggle clk_out at terminal count.
// Divisor changes go through a shadow and apply at terminal count (or at once while idle).
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = C_WIDTH,
  parameter int DEF_DIV = C_DEF_DIV
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] shadow;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count   <= '0;
      div     <= DEF;
      shadow  <= DEF;
      pending <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (count == div) begin
          count   <= '0;
          tick    <= 1'b1;
          clk_out <= ~clk_out;
          pending <= 1'b0;
          // A write landing on the terminal edge wins over any older shadow.
          if (wr) begin
            div    <= wr_div;
            shadow <= wr_div;
          end else if (pending) begin
            div <= shadow;
          end
        end else begin
          count <= count + WIDTH'(1);
          if (wr) begin
            shadow  <= wr_div;
            pending <= 1'b1;
          end
        end
      end else if (wr) begin
        shadow  <= wr_div;
        pending <= 1'b1;
      end else if (pending) begin
        // Idle channel: apply now, clamping the held count into the new range.
        div     <= shadow;
        pending <= 1'b0;
        if (count > shadow) count <= '0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers with a shared divisor write port.
// Holds only write decode and the registered cfg_ack; channels are clk_div_chan.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH     = C_NCH,
  parameter int WIDTH   = C_WIDTH,
  parameter int DEF_DIV = C_DEF_DIV
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic                   cfg_we,
  input  logic [ch_w(NCH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]       cfg_div,
  output logic                   cfg_ack,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         clk_out,
  output logic [NCH-1:0]         pending
);

  logic wr_ok;

  // Out-of-range channel numbers are dropped silently.
  assign wr_ok = cfg_we && (int'(cfg_ch) < NCH);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) cfg_ack <= 1'b0;
    else     cfg_ack <= wr_ok;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .wr      (wr_ok && (int'(cfg_ch) == i)),
      .wr_div  (cfg_div),
      .tick    (tick[i]),
      .clk_out (clk_out[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed and randomized checks of clk_div_bank against a remaining-cycles model.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH     = 5;
  localparam int WIDTH   = 20;
  localparam int DEF_DIV = 40;
  localparam int CHW     = ch_w(NCH);

  logic             clk_in;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ack;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   pending;

  clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_ack (cfg_ack),
    .tick    (tick),
    .clk_out (clk_out),
    .pending (pending)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Model: cycles remaining until terminal, plus toggle parity.
  int m_div [NCH];
  int m_sh  [NCH];
  int m_rem [NCH];
  bit m_pend[NCH];
  bit m_tick[NCH];
  bit m_clk [NCH];
  bit m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEF_DIV; m_sh[i] = DEF_DIV; m_rem[i] = DEF_DIV;
      m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
    end
    m_ack = 0;
  endtask

  task automatic model_update();
    bit acc;
    int d, cur;
    if (rst) begin
      model_reset();
      return;
    end
    acc = cfg_we && (int'(cfg_ch) < NCH);
    d   = int'(cfg_div);
    for (int i = 0; i < NCH; i++) begin
      bit w;
      w = acc && (int'(cfg_ch) == i);
      m_tick[i] = 0;
      if (en[i]) begin
        if (m_rem[i] == 0) begin
          m_tick[i] = 1;
          m_clk[i]  = !m_clk[i];
          if (w) m_div[i] = d;
          else if (m_pend[i]) m_div[i] = m_sh[i];
          if (w) m_sh[i] = d;
          m_pend[i] = 0;
          m_rem[i]  = m_div[i];
        end else begin
          m_rem[i]--;
          if (w) begin m_sh[i] = d; m_pend[i] = 1; end
        end
      end else if (w) begin
        m_sh[i] = d; m_pend[i] = 1;
      end else if (m_pend[i]) begin
        cur = m_div[i] - m_rem[i];
        if (cur > m_sh[i]) cur = 0;
        m_div[i]  = m_sh[i];
        m_rem[i]  = m_div[i] - cur;
        m_pend[i] = 0;
      end
    end
    m_ack = acc;
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] et, ec, ep;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick[i]; ec[i] = m_clk[i]; ep[i] = m_pend[i];
    end
    chk("tick", 32'(tick), 32'(et));
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("pending", 32'(pending), 32'(ep));
    chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
  endtask

  task automatic step();
    @(posedge clk_in);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_div = WIDTH'(d);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin step(); n++; end while (!tick[ch] && n < limit);
  endtask

  task automatic wait_rise(input int ch, input int limit, output int n);
    logic prev;
    n = 0;
    do begin prev = clk_out[ch]; step(); n++; end
    while (!(clk_out[ch] && !prev) && n < limit);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tick"}, 32'(tick), 0);
    chk({tag, "_clk"}, 32'(clk_out), 0);
    chk({tag, "_pend"}, 32'(pending), 0);
    chk({tag, "_ack"}, 32'(cfg_ack), 0);
  endtask

  initial begin
    int n, k, seen, toggles;
    logic c0;
    rst = 1'b1; en = '1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    step(); step();
    rst = 1'b0;

    // First tick after release comes DEF_DIV+1 cycles later.
    wait_tick(0, 200, n);
    chk("first_tick", n, DEF_DIV + 1);

    // Mid-period divisor write on ch1: pending until old terminal, then period 8.
    repeat (10) step();
    wr(1, 3);
    chk("ch1_ack", 32'(cfg_ack), 1);
    chk("ch1_pend", 32'(pending[1]), 1);
    wait_tick(1, 200, n);
    chk("ch1_pend_clr", 32'(pending[1]), 0);
    wait_rise(1, 50, n);
    wait_rise(1, 50, n);
    chk("ch1_period", n, 8);

    // div=0 on ch2: tick every cycle, clk_out toggling every cycle.
    wr(2, 0);
    wait_tick(2, 200, n);
    toggles = 0;
    for (int i = 0; i < 4; i++) begin
      c0 = clk_out[2];
      step();
      chk("div0_tick", 32'(tick[2]), 1);
      if (clk_out[2] != c0) toggles++;
    end
    chk("div0_toggles", toggles, 4);

    // Pause ch0 at count 10 for 100 cycles.
    k = 0;
    while ((m_div[0] - m_rem[0]) != 10 && k < 200) begin step(); k++; end
    chk("ch0_found_cnt10", m_div[0] - m_rem[0], 10);
    en[0] = 1'b0;
    c0 = clk_out[0];
    seen = 0;
    repeat (100) begin step(); if (tick[0]) seen++; end
    chk("pause_no_tick", seen, 0);
    chk("pause_frozen", 32'(clk_out[0]), 32'(m_clk[0]));
    chk("pause_frozen_dut", 32'(clk_out[0]), 32'(c0));
    en[0] = 1'b1;
    wait_tick(0, 200, n);
    chk("resume_tick", n, DEF_DIV - 10 + 1);

    // Out-of-range channel: no ack, no pending.
    wr(NCH, 7);
    chk("badch_ack", 32'(cfg_ack), 0);
    chk("badch_pend", 32'(pending), 0);
    wr(7, 2);
    chk("badch7_ack", 32'(cfg_ack), 0);

    // Write coinciding with terminal count on ch1: immediate, no pending.
    k = 0;
    while (m_rem[1] != 0 && k < 20) begin step(); k++; end
    wr(1, 6);
    chk("coin_tick", 32'(tick[1]), 1);
    chk("coin_pend", 32'(pending[1]), 0);
    chk("coin_ack", 32'(cfg_ack), 1);
    wait_tick(1, 50, n);
    chk("coin_half", n, 7);

    // Reset mid-period with ch3 pending.
    k = 0;
    while (m_rem[3] < 3 && k < 100) begin step(); k++; end
    wr(3, 9);
    chk("rst_pre_pend", 32'(pending[3]), 1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    step(); step();
    rst = 1'b0;
    wait_tick(3, 200, n);
    chk("rst_ch3_tick", n, DEF_DIV + 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      en = NCH'($urandom) | NCH'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        cfg_we  = 1'b1;
        cfg_ch  = CHW'($urandom_range(0, 7));
        cfg_div = WIDTH'($urandom_range(0, 12));
      end else begin
        cfg_we = 1'b0;
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("rand_rst");
      end
      step();
      rst = 1'b0;
    end
    cfg_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
